modulo_folder: RTL and testbench
================================

// Module: modulo_folder
// PURPOSE
//  Transmit-side model of the modulo ADC: folds a column of ROWS unbounded signed samples
//  into [-L, L) and records the per-sample fold count k (in = out + 2L*k).
//  Its output column is the input of the fold-removal/unfolding stage. It also serves as
//  the self-test stimulus source for that stage.
//  Works serially, one element at a time, with an iterative fold.
// PARAMETERS
//  ROWS       J+1   column length (J, L, OUT_RES are the shared constants in functions.sv)
//  IN_RES     24    signed width of the unfolded input samples
//  MAX_FOLDS  15    max |k| per sample before saturation; KW = $clog2(MAX_FOLDS+1)+1
// PORTS
//  clk        in   1                    single clock, rising edge
//  reset      in   1                    synchronous, active-high
//  en         in   1                    start pulse; samples in[] when idle
//  in         in   [IN_RES-1:0] x ROWS  signed unfolded column
//  out        out  [OUT_RES-1:0] x ROWS signed folded column, each in [-L, L)
//  fold_k     out  [KW-1:0] x ROWS      signed fold count per element
//  fold_flag  out  [ROWS-1:0]           1 where fold_k[n] != fold_k[n-1] (fold_k[-1] = 0)
//  busy       out  1                    high from the cycle after en until DONE
//  done       out  1                    one-cycle pulse when the whole column is committed
//  overflow   out  1                    sticky per frame: some |k| hit MAX_FOLDS, sample clipped
// BEHAVIOUR
//  - Reset (wins over everything): all out/fold_k = 0, fold_flag = 0, busy/done/overflow = 0,
//    state = IDLE. A reset mid-frame abandons the frame; no done pulse.
//  - FSM IDLE -> FOLD -> DONE -> IDLE.
//    IDLE & en: snapshot in[] into an internal array, n <= 0, acc <= sign-ext(in[0]) (IN_RES+1 b),
//      k <= 0, overflow <= 0, go to FOLD.
//    en is ignored outside IDLE.
//  - FOLD does one action per cycle on element n:
//      acc >= L               : acc -= 2L, k += 1
//      acc < -L               : acc += 2L, k -= 1
//      else (in range)        : commit out[n] = acc[OUT_RES-1:0], fold_k[n] = k,
//                               fold_flag[n] = (k != k_prev)
//      |k| == MAX_FOLDS and still out of range: commit clipped value (L-1 if acc >= L, else -L)
//                               with fold_k[n] = k, and set overflow.
//    On commit: k_prev <= k, n++, and the next acc/k load from the snapshot.
//    After committing n == ROWS-1 go to DONE.
//  - Range is half-open: acc == L folds to -L (k+1); acc == -L is kept.
//  - Element n takes |k_n|+1 FOLD cycles. With T = sum over n of (|k_n|+1), done is high in the
//    cycle after the T-th FOLD edge. DONE lasts 1 cycle, then IDLE.
//    The same-cycle en is ignored; en is accepted from the next cycle.
//  - out/fold_k/fold_flag update element-by-element during FOLD. They are a coherent frame
//    only from done until the next accepted en, and hold until then.
//    Elements not yet committed hold the previous frame.
//  - 2L computed at IN_RES+1 bits; no wraparound in acc for |in| < 2^(IN_RES-1).
// STRUCTURE
//  - Shared: L, J, OUT_RES stay in functions.sv. Add typedef enum {IDLE,FOLD,DONE} fold_state_t
//    and localparam TWO_L there so the unfolding stage's bench can reuse them.
//  - One sub-module, fold_step (combinational): acc,k -> acc_next, k_next, in_range, sat.
//    The top holds the FSM, counter n, snapshot array and output registers.
// TESTING (L = 512, ROWS = 19)
//  - All samples 100 -> out = 100, fold_k = 0, fold_flag = 0; done 20 cycles after en; overflow 0.
//  - in[3] = 512, in[4] = -512, rest 0 -> out[3] = -512, fold_k[3] = 1, fold_flag[3] = fold_flag[4] = 1;
//    out[4] = -512, fold_k[4] = 0.
//  - Ramp in[n] = 300*n -> out[n] = in[n] - 1024*k_n, every out in [-512, 511];
//    done after sum(|k_n|+1) + 1 cycles.
//  - in[0] = 40000 (needs k = 39 > 15) -> out[0] = 511, fold_k[0] = 15, overflow = 1 until next en.
//  - reset asserted mid-FOLD -> next cycle all outputs 0, busy 0, no done;
//    a new en then runs a clean frame.
//  - en held high throughout: exactly one frame per IDLE visit; en during FOLD/DONE ignored.
//  - Loopback: feed out into the unfolding stage -> reconstruction equals in for |k| <= 1 steps.

Source files
------------

// File: rtl/modulo_folder_pkg.sv
// Constants and types shared by the folding stage and the fold-removal stage
// (and by the benches of both).
package modulo_folder_pkg;
  localparam int J             = 18;
  localparam int L             = 512;
  localparam int OUT_RES       = 10;
  localparam int TWO_L         = 2 * L;
  localparam int ROWS_DEF      = J + 1;
  localparam int IN_RES_DEF    = 24;
  localparam int MAX_FOLDS_DEF = 15;

  typedef enum logic [1:0] {IDLE, FOLD, DONE} fold_state_t;

  function automatic int kw_of(input int max_folds);
    return $clog2(max_folds + 1) + 1;
  endfunction
endpackage

// File: rtl/modulo_folder_if.sv
// Column bus of the modulo folder: start pulse and input column in, folded column and status out.
interface modulo_folder_if
  import modulo_folder_pkg::*;
#(
  parameter int ROWS   = ROWS_DEF,
  parameter int IN_RES = IN_RES_DEF,
  parameter int KW     = kw_of(MAX_FOLDS_DEF)
);
  logic                             en;
  logic [ROWS-1:0][IN_RES-1:0]      in;
  logic [ROWS-1:0][OUT_RES-1:0]     out;
  logic [ROWS-1:0][KW-1:0]          fold_k;
  logic [ROWS-1:0]                  fold_flag;
  logic                             busy;
  logic                             done;
  logic                             overflow;

  modport master (output en, in, input out, fold_k, fold_flag, busy, done, overflow);
  modport slave  (input en, in, output out, fold_k, fold_flag, busy, done, overflow);
endinterface

// File: rtl/modulo_folder_fold_step.sv
// One iteration of the fold: moves acc one 2L step toward [-L, L) and reports
// whether the current value can be committed (in range, or clipped at the fold limit).
module modulo_folder_fold_step
  import modulo_folder_pkg::*;
#(
  parameter int IN_RES    = IN_RES_DEF,
  parameter int KW        = kw_of(MAX_FOLDS_DEF),
  parameter int MAX_FOLDS = MAX_FOLDS_DEF
) (
  input  logic signed [IN_RES:0]  acc,
  input  logic signed [KW-1:0]    k,
  output logic signed [IN_RES:0]  acc_next,
  output logic signed [KW-1:0]    k_next,
  output logic                    in_range,
  output logic                    sat,
  output logic [OUT_RES-1:0]      commit_val
);
  localparam logic signed [IN_RES:0] L_S     = (IN_RES+1)'(L);
  localparam logic signed [IN_RES:0] NEG_L_S = (IN_RES+1)'(-L);
  localparam logic signed [IN_RES:0] TWO_L_S = (IN_RES+1)'(TWO_L);
  localparam logic signed [KW-1:0]   K_ONE   = KW'(1);
  localparam logic signed [KW-1:0]   K_MAX   = KW'(MAX_FOLDS);
  localparam logic signed [KW-1:0]   K_MIN   = KW'(-MAX_FOLDS);
  localparam logic [OUT_RES-1:0]     CLIP_HI = OUT_RES'(L - 1);
  localparam logic [OUT_RES-1:0]     CLIP_LO = OUT_RES'(-L);

  logic above;
  logic below;

  // Half-open range: +L folds down, -L is kept.
  assign above    = (acc >= L_S);
  assign below    = (acc < NEG_L_S);
  assign in_range = !above && !below;
  assign sat      = !in_range && ((k == K_MAX) || (k == K_MIN));

  always_comb begin
    acc_next = acc;
    k_next   = k;
    if (above) begin
      acc_next = acc - TWO_L_S;
      k_next   = k + K_ONE;
    end else if (below) begin
      acc_next = acc + TWO_L_S;
      k_next   = k - K_ONE;
    end
  end

  assign commit_val = in_range ? acc[OUT_RES-1:0] : (above ? CLIP_HI : CLIP_LO);
endmodule

// File: rtl/modulo_folder.sv
// Serial modulo folder: snapshots a column on en and folds one element at a time.
// state | meaning
// IDLE  | waiting for en; outputs hold the last frame
// FOLD  | folding/committing element n, one fold step per cycle
// DONE  | whole column committed, done pulse
module modulo_folder
  import modulo_folder_pkg::*;
#(
  parameter int ROWS      = ROWS_DEF,
  parameter int IN_RES    = IN_RES_DEF,
  parameter int MAX_FOLDS = MAX_FOLDS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  modulo_folder_if.slave   bus
);
  localparam int KW = kw_of(MAX_FOLDS);
  localparam int NW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [NW-1:0] LAST = NW'(ROWS - 1);

  fold_state_t                  state;
  logic [NW-1:0]                n;
  logic [ROWS-1:0][IN_RES-1:0]  snap;
  logic signed [IN_RES:0]       acc;
  logic signed [KW-1:0]         k;
  logic signed [KW-1:0]         k_prev;

  logic signed [IN_RES:0]       acc_next;
  logic signed [KW-1:0]         k_next;
  logic                         in_range;
  logic                         sat;
  logic [OUT_RES-1:0]           commit_val;

  modulo_folder_fold_step #(
    .IN_RES    (IN_RES),
    .KW        (KW),
    .MAX_FOLDS (MAX_FOLDS)
  ) u_fold_step (
    .acc        (acc),
    .k          (k),
    .acc_next   (acc_next),
    .k_next     (k_next),
    .in_range   (in_range),
    .sat        (sat),
    .commit_val (commit_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      n             <= '0;
      snap          <= '0;
      acc           <= '0;
      k             <= '0;
      k_prev        <= '0;
      bus.out       <= '0;
      bus.fold_k    <= '0;
      bus.fold_flag <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en) begin
            snap         <= bus.in;
            n            <= '0;
            acc          <= {bus.in[0][IN_RES-1], bus.in[0]};
            k            <= '0;
            k_prev       <= '0;
            bus.overflow <= 1'b0;
            bus.busy     <= 1'b1;
            state        <= FOLD;
          end
        end
        FOLD: begin
          if (in_range || sat) begin
            bus.out[n]       <= commit_val;
            bus.fold_k[n]    <= k;
            bus.fold_flag[n] <= (k != k_prev);
            k_prev           <= k;
            k                <= '0;
            if (sat) bus.overflow <= 1'b1;
            if (n == LAST) begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              n   <= n + 1'b1;
              acc <= {snap[n + 1'b1][IN_RES-1], snap[n + 1'b1]};
            end
          end else begin
            acc <= acc_next;
            k   <= k_next;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_modulo_folder.sv
// Scoreboard bench for modulo_folder: a floor-division reference model predicts each frame,
// a negedge monitor checks every done pulse against the queued prediction.
module tb_modulo_folder;
  import modulo_folder_pkg::*;

  localparam int ROWS   = ROWS_DEF;
  localparam int IN_RES = IN_RES_DEF;
  localparam int MAXF   = MAX_FOLDS_DEF;
  localparam int KW     = kw_of(MAXF);

  typedef struct {
    logic [ROWS-1:0][OUT_RES-1:0] out;
    logic [ROWS-1:0][KW-1:0]      k;
    logic [ROWS-1:0]              flag;
    logic                         ovf;
    logic [ROWS-1:0][IN_RES-1:0]  x;
    int                           done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  modulo_folder_if #(.ROWS(ROWS), .IN_RES(IN_RES), .KW(KW)) bus ();

  modulo_folder #(.ROWS(ROWS), .IN_RES(IN_RES), .MAX_FOLDS(MAXF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   stim[ROWS];
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: k = floor((x + L) / 2L), limited to +-MAXF with clipping.
  function automatic exp_t model(input int accept_cyc);
    exp_t e;
    int   kp, t, num, q, o;
    kp = 0;
    t  = 0;
    e.ovf = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      num = stim[i] + L;
      q   = num / TWO_L;
      if ((num % TWO_L) != 0 && num < 0) q = q - 1;
      if (q > MAXF) begin
        q = MAXF; o = L - 1; e.ovf = 1'b1;
      end else if (q < -MAXF) begin
        q = -MAXF; o = -L; e.ovf = 1'b1;
      end else begin
        o = stim[i] - TWO_L * q;
      end
      e.out[i]  = OUT_RES'(o);
      e.k[i]    = KW'(q);
      e.flag[i] = (q != kp);
      e.x[i]    = IN_RES'(stim[i]);
      kp = q;
      t  = t + ((q < 0) ? -q : q) + 1;
    end
    e.done_cyc = accept_cyc + t;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int   rec;
    int   kk;
    logic lb_ok;
    if (!reset && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual done=1 required no done (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.done_cyc);
        check("out", bus.out, e.out);
        check("fold_k", bus.fold_k, e.k);
        check("fold_flag", bus.fold_flag, e.flag);
        check("overflow", bus.overflow, e.ovf);
        check("busy_at_done", bus.busy, 1'b0);
        lb_ok = 1'b1;
        for (int i = 0; i < ROWS; i++) begin
          kk  = int'($signed(bus.fold_k[i]));
          rec = int'($signed(bus.out[i])) + TWO_L * kk;
          if (kk != MAXF && kk != -MAXF && rec != int'($signed(e.x[i]))) lb_ok = 1'b0;
        end
        check("loopback", lb_ok, 1'b1);
      end
    end
  end

  task automatic issue(input bit hold, output int accept_cyc);
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < ROWS; i++) bus.in[i] = IN_RES'(stim[i]);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    e = model(accept_cyc);
    sb.push_back(e);
    check("busy_after_en", bus.busy, 1'b1);
    check("overflow_cleared_on_en", bus.overflow, 1'b0);
    if (!hold) begin
      @(negedge clk);
      bus.en = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while (sb.size() != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual %0d pending required 0 pending", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic run_frame();
    int a;
    issue(1'b0, a);
    wait_drain(2000);
  endtask

  function automatic int rand_val();
    int b[8];
    b = '{L, -L, L - 1, -L - 1, 3 * L, -3 * L, 3 * L - 1, -3 * L - 1};
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 1200)) - 600;
      1:       return int'($urandom_range(0, 16000)) - 8000;
      2:       return b[$urandom_range(0, 7)];
      default: return ($urandom_range(0, 1) != 0) ? int'($urandom_range(15000, 40000))
                                                  : -int'($urandom_range(15000, 40000));
    endcase
  endfunction

  initial begin
    int a;
    int t;
    exp_t e;
    reset  = 1'b1;
    bus.en = 1'b0;
    bus.in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", bus.out, '0);
    check("rst_fold_k", bus.fold_k, '0);
    check("rst_flag", bus.fold_flag, '0);
    check("rst_status", {bus.busy, bus.done, bus.overflow}, 3'b000);
    @(negedge clk);
    reset = 1'b0;

    // Constant in-range column
    foreach (stim[i]) stim[i] = 100;
    run_frame();

    // Half-open boundaries
    foreach (stim[i]) stim[i] = 0;
    stim[3] = L;
    stim[4] = -L;
    run_frame();

    // Ramp
    foreach (stim[i]) stim[i] = 300 * i;
    run_frame();

    // Saturation both ways, overflow stays sticky and outputs hold after the frame
    foreach (stim[i]) stim[i] = 7;
    stim[0] = 40000;
    stim[9] = -40000;
    run_frame();
    repeat (5) @(posedge clk);
    #1;
    check("overflow_sticky", bus.overflow, 1'b1);
    check("out0_hold", bus.out[0], OUT_RES'(L - 1));

    // Reset in the middle of a frame abandons it
    foreach (stim[i]) stim[i] = 5000 - 700 * i;
    issue(1'b0, a);
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out", bus.out, '0);
    check("midrst_fold_k", bus.fold_k, '0);
    check("midrst_status", {bus.busy, bus.done, bus.overflow}, 3'b000);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    foreach (stim[i]) stim[i] = 100;
    run_frame();

    // en held high: one frame per IDLE visit, period T+2
    foreach (stim[i]) stim[i] = 1500 - 150 * i;
    issue(1'b1, a);
    e = sb[sb.size() - 1];
    t = e.done_cyc - a;
    for (int f = 1; f < 3; f++) begin
      e = model(a + f * (t + 2));
      sb.push_back(e);
    end
    repeat (2 * (t + 2)) @(posedge clk);
    @(negedge clk);
    bus.en = 1'b0;
    wait_drain(2000);
    repeat (20) @(posedge clk);

    // Random columns
    for (int f = 0; f < 20; f++) begin
      foreach (stim[i]) stim[i] = rand_val();
      run_frame();
    end

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
